// File: rtl/sw_arb_pkg.sv
// rtl/sw_arb_pkg.sv - shared types and sizing helpers for the switch egress arbiter
package sw_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int FRAME_CNT_WIDTH = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first requester after last_i, wrapping
module rr_pick #(
  parameter int P_N  = 4,
  parameter int P_IW = 2
) (
  input  logic [P_N-1:0]  req_i,
  input  logic [P_IW-1:0] last_i,
  output logic [P_N-1:0]  grant_o,
  output logic [P_IW-1:0] idx_o,
  output logic            any_req_o
);

  logic [2*P_N-1:0] w_dbl;
  logic [P_N-1:0]   w_rot;
  logic             w_found;
  int               w_sel;

  // Doubling the vector turns the wrap-around scan into a plain shift.
  assign w_dbl     = {req_i, req_i};
  assign any_req_o = |req_i;

  always_comb begin
    w_rot   = P_N'(w_dbl >> (int'(last_i) + 1));
    w_found = 1'b0;
    w_sel   = 0;
    for (int j = 0; j < P_N; j++) begin
      if (!w_found && w_rot[j]) begin
        w_found = 1'b1;
        w_sel   = (int'(last_i) + 1 + j) % P_N;
      end
    end
    grant_o = w_found ? (P_N'(1) << w_sel) : '0;
    idx_o   = P_IW'(w_sel);
  end

endmodule

// File: rtl/switch_egress_arbiter.sv
// rtl/switch_egress_arbiter.sv - frame-atomic round-robin egress arbiter over FWFT FIFOs
// Optional starvation abort enabled by defining SW_ARB_TIMEOUT_EN.
module switch_egress_arbiter
  import sw_arb_pkg::*;
#(
  parameter int P_NUM_PORTS  = 4,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_TIMEOUT    = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [P_NUM_PORTS-1:0]            fifo_empty_i,
  input  logic [P_NUM_PORTS*P_DATA_WIDTH-1:0] fifo_data_i,
  input  logic [P_NUM_PORTS-1:0]            fifo_last_i,
  output logic [P_NUM_PORTS-1:0]            fifo_rd_o,
  output logic [P_DATA_WIDTH-1:0]           m_data_o,
  output logic                              m_last_o,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic [P_NUM_PORTS-1:0]            grant_o,
  output logic                              busy_o,
  output logic [FRAME_CNT_WIDTH-1:0]        frame_cnt_o,
  output logic                              abort_o
);

  localparam int LP_IW = idx_width(P_NUM_PORTS);

  arb_state_t                 r_state;
  logic [P_NUM_PORTS-1:0]     r_grant;
  logic [LP_IW-1:0]           r_gidx;
  logic [LP_IW-1:0]           r_last_grant;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;

  logic [P_NUM_PORTS-1:0]     w_req;
  logic [P_NUM_PORTS-1:0]     w_pick_grant;
  logic [LP_IW-1:0]           w_pick_idx;
  logic                       w_any_req;
  logic                       w_busy;
  logic                       w_valid;
  logic                       w_accept;
  logic                       w_head_last;
  logic [P_DATA_WIDTH-1:0]    w_head_data;
  logic                       w_timeout;

  assign w_req = ~fifo_empty_i;

  rr_pick #(
    .P_N  (P_NUM_PORTS),
    .P_IW (LP_IW)
  ) u_rr_pick (
    .req_i     (w_req),
    .last_i    (r_last_grant),
    .grant_o   (w_pick_grant),
    .idx_o     (w_pick_idx),
    .any_req_o (w_any_req)
  );

  // The granted FIFO head goes straight to the egress with no pipeline stage.
  assign w_busy      = (r_state == XFER);
  assign w_valid     = w_busy & ~fifo_empty_i[r_gidx];
  assign w_head_data = fifo_data_i[r_gidx*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign w_head_last = fifo_last_i[r_gidx];
  assign w_accept    = w_valid & m_ready_i;

  assign m_valid_o   = w_valid;
  assign m_data_o    = w_busy ? w_head_data : '0;
  assign m_last_o    = w_busy & w_head_last;
  assign fifo_rd_o   = w_accept ? r_grant : '0;
  assign grant_o     = r_grant;
  assign busy_o      = w_busy;
  assign frame_cnt_o = r_frame_cnt;

`ifdef SW_ARB_TIMEOUT_EN
  localparam int LP_SW_RAW = $clog2(P_TIMEOUT + 1);
  localparam int LP_SW     = (LP_SW_RAW < 8) ? 8 : ((LP_SW_RAW > 16) ? 16 : LP_SW_RAW);

  logic [LP_SW-1:0] r_stall;
  logic             r_abort;

  assign w_timeout = w_busy & fifo_empty_i[r_gidx] & (r_stall == LP_SW'(P_TIMEOUT - 1));
  assign abort_o   = r_abort;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall <= '0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_timeout;
      if (!w_busy || !fifo_empty_i[r_gidx] || w_timeout) begin
        r_stall <= '0;
      end else begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (P_TIMEOUT == 0);
  assign w_timeout        = 1'b0;
  assign abort_o          = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_gidx       <= '0;
      r_last_grant <= LP_IW'(P_NUM_PORTS - 1);
      r_frame_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant      <= w_pick_grant;
            r_gidx       <= w_pick_idx;
            r_last_grant <= w_pick_idx;
            r_state      <= XFER;
          end
        end
        XFER: begin
          if (w_accept && w_head_last) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_grant     <= '0;
            r_state     <= IDLE;
          end else if (w_timeout) begin
            r_grant <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_egress_arbiter.sv
// tb/tb_switch_egress_arbiter.sv - scoreboard bench for switch_egress_arbiter
module tb_switch_egress_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   fifo_empty_i;
  logic [N*W-1:0] fifo_data_i;
  logic [N-1:0]   fifo_last_i;
  logic [N-1:0]   fifo_rd_o;
  logic [W-1:0]   m_data_o;
  logic           m_last_o;
  logic           m_valid_o;
  logic           m_ready_i;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic [15:0]    frame_cnt_o;
  logic           abort_o;

  always #5 clk = ~clk;

  switch_egress_arbiter #(
    .P_NUM_PORTS  (N),
    .P_DATA_WIDTH (W),
    .P_TIMEOUT    (8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_last_i  (fifo_last_i),
    .fifo_rd_o    (fifo_rd_o),
    .m_data_o     (m_data_o),
    .m_last_o     (m_last_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .grant_o      (grant_o),
    .busy_o       (busy_o),
    .frame_cnt_o  (frame_cnt_o),
    .abort_o      (abort_o)
  );

  int passed = 0;
  int total  = 0;

  logic [8:0] fq [N][$];
  logic [8:0] exp_q[$];
  int         grant_log[$];
  int         acc_cyc[$];
  int         pops[N];
  int         cyc = 0;
  int         abort_cnt = 0;
  logic [N-1:0] pop_mask = '0;
  logic [8:0] prev_beat = '0;
  logic       prev_stall = 1'b0;
  logic [N-1:0] prev_grant = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  function automatic void refresh();
    for (int k = 0; k < N; k++) begin
      fifo_empty_i[k]       = (fq[k].size() == 0);
      fifo_data_i[k*W +: W] = (fq[k].size() != 0) ? fq[k][0][7:0] : 8'h00;
      fifo_last_i[k]        = (fq[k].size() != 0) ? fq[k][0][8] : 1'b0;
    end
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic push(input int p, input logic [7:0] d, input logic l);
    fq[p].push_back({l, d});
    refresh();
  endtask

  task automatic clear_pops();
    for (int k = 0; k < N; k++) pops[k] = 0;
  endtask

  // FIFO model: pops latched mid-cycle are applied just after the edge.
  always @(posedge clk) cyc++;
  always @(negedge clk) pop_mask = fifo_rd_o;
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (pop_mask[k] && fq[k].size() > 0) begin
        void'(fq[k].pop_front());
        pops[k]++;
      end
    end
    pop_mask = '0;
    refresh();
  end

  // Monitor: scoreboard pops on every accepted beat.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_ni) begin
      prev_stall = 1'b0;
      prev_grant = '0;
    end else begin
      if (abort_o) abort_cnt++;
      if (grant_o != 0 && prev_grant == 0) grant_log.push_back(onehot_idx(grant_o));
      prev_grant = grant_o;
      if (prev_stall) chk("stall_hold", {m_valid_o, m_last_o, m_data_o}, {1'b1, prev_beat});
      if (m_valid_o && m_ready_i) begin
        chk("rd_strobe", fifo_rd_o, grant_o);
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_beat", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("beat", {m_last_o, m_data_o}, e);
        end
      end else if (fifo_rd_o != 0) begin
        chk("rd_no_accept", fifo_rd_o, 0);
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_beat  = {m_last_o, m_data_o};
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, grant_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_rd"}, fifo_rd_o, 0);
    chk({tag, "_valid"}, m_valid_o, 0);
    chk({tag, "_last"}, m_last_o, 0);
    chk({tag, "_data"}, m_data_o, 0);
    chk({tag, "_frames"}, frame_cnt_o, 0);
    chk({tag, "_abort"}, abort_o, 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    for (int k = 0; k < N; k++) fq[k].delete();
    exp_q.delete();
    refresh();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_busy(input int max_cyc);
    int n;
    n = 0;
    while (!busy_o && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_busy", busy_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic rp [6];
    int   bad;
    rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst_ni    = 1'b0;
    m_ready_i = 1'b1;
    clear_pops();
    refresh();
    repeat (2) @(posedge clk);
    #1 check_reset_vals("rst");
    rst_ni = 1'b1;

    // All FIFOs empty: nothing may be granted or popped.
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant_o != 0 || m_valid_o || fifo_rd_o != 0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Two 3-beat frames on ports 0 and 2.
    @(posedge clk); #1;
    acc_cyc.delete(); grant_log.delete(); clear_pops();
    push(0, 8'hA1, 0); push(0, 8'hA2, 0); push(0, 8'hA3, 1);
    push(2, 8'hC1, 0); push(2, 8'hC2, 0); push(2, 8'hC3, 1);
    exp_q = '{9'h0A1, 9'h0A2, 9'h1A3, 9'h0C1, 9'h0C2, 9'h1C3};
    wait_drain(100);
    chk("t2_frames", frame_cnt_o, 2);
    chk("t2_pops0", pops[0], 3);
    chk("t2_pops2", pops[2], 3);
    chk("t2_ngrant", grant_log.size(), 2);
    chk("t2_nbeats", acc_cyc.size(), 6);
    if (grant_log.size() == 2) begin
      chk("t2_g0", grant_log[0], 0);
      chk("t2_g1", grant_log[1], 2);
    end
    if (acc_cyc.size() == 6) begin
      chk("t2_back2back", acc_cyc[1] - acc_cyc[0], 1);
      chk("t2_bubble", acc_cyc[3] - acc_cyc[2], 2);
    end

    // Four ports with two 2-beat frames each: strict rotation.
    do_reset();
    grant_log.delete();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < N; p++)
        for (int b = 0; b < 2; b++) begin
          push(p, 8'((p + 1) * 16 + f * 4 + b), (b == 1));
          exp_q.push_back({(b == 1), 8'((p + 1) * 16 + f * 4 + b)});
        end
    exp_q.delete();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < N; p++)
        for (int b = 0; b < 2; b++) exp_q.push_back({(b == 1), 8'((p + 1) * 16 + f * 4 + b)});
    wait_drain(200);
    chk("t3_frames", frame_cnt_o, 8);
    chk("t3_ngrant", grant_log.size(), 8);
    if (grant_log.size() == 8)
      for (int i = 0; i < 8; i++) chk($sformatf("t3_order%0d", i), grant_log[i], i % 4);

    // Backpressure on a 4-beat frame from port 1.
    @(posedge clk); #1;
    acc_cyc.delete(); clear_pops();
    push(1, 8'h51, 0); push(1, 8'h52, 0); push(1, 8'h53, 0); push(1, 8'h54, 1);
    exp_q = '{9'h051, 9'h052, 9'h053, 9'h154};
    wait_busy(10);
    m_ready_i = rp[0];
    for (int k = 1; k < 6; k++) begin
      @(posedge clk); #1;
      m_ready_i = rp[k];
    end
    m_ready_i = 1'b1;
    wait_drain(50);
    chk("t4_pops1", pops[1], 4);
    chk("t4_frames", frame_cnt_o, 9);
    chk("t4_nbeats", acc_cyc.size(), 4);
    if (acc_cyc.size() == 4) chk("t4_stall_gap", acc_cyc[1] - acc_cyc[0], 3);

    // Port 1 starves mid-frame while port 3 waits.
    do_reset();
    grant_log.delete();
    abort_cnt = 0;
    push(1, 8'h61, 0); push(1, 8'h62, 0);
    push(3, 8'h71, 0); push(3, 8'h72, 1);
    exp_q = '{9'h061, 9'h062};
`ifdef SW_ARB_TIMEOUT_EN
    exp_q.push_back(9'h071);
    exp_q.push_back(9'h172);
    wait_drain(100);
    chk("t5_abort", abort_cnt, 1);
    chk("t5_frames", frame_cnt_o, 1);
    chk("t5_ngrant", grant_log.size(), 2);
    if (grant_log.size() == 2) chk("t5_next", grant_log[1], 3);
`else
    repeat (40) @(negedge clk);
    chk("t5_held", grant_o, 4'b0010);
    chk("t5_busy", busy_o, 1);
    chk("t5_valid", m_valid_o, 0);
    chk("t5_sent", exp_q.size(), 0);
    chk("t5_abort", abort_cnt, 0);
`endif

    // Reset asserted on beat 2 of a 5-beat frame.
    do_reset();
    clear_pops();
    for (int b = 0; b < 5; b++) push(2, 8'(8'h81 + b), (b == 4));
    exp_q = '{9'h081};
    wait_busy(10);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    #1 check_reset_vals("midrst");
    chk("midrst_sent", exp_q.size(), 0);
    grant_log.delete();
    push(0, 8'h91, 0); push(0, 8'h92, 1);
    exp_q = '{9'h091, 9'h192, 9'h082, 9'h083, 9'h084, 9'h185};
    @(posedge clk); #1 rst_ni = 1'b1;
    wait_drain(100);
    chk("t6_ngrant", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t6_first", grant_log[0], 0);
      chk("t6_second", grant_log[1], 2);
    end
    chk("t6_frames", frame_cnt_o, 2);
    chk("t6_pops2", pops[2], 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/switch_egress_arbiter.md
Name: switch_egress_arbiter

Overview:
- Shares one egress port between P_NUM_PORTS per-ingress FWFT sync FIFOs in the network switch.
- Grants are round-robin and frame-atomic: once a port is granted, the arbiter drains it until a beat with its last flag is accepted.
- It drives the FIFO pop strobes and presents the selected FIFO head on a valid/ready stream toward the egress MAC.

Parameters:
- P_NUM_PORTS, 4: number of ingress FIFOs (2..16).
- P_DATA_WIDTH, 8: payload width per beat.
- P_TIMEOUT, 255: starvation cycles before a frame is aborted. Only used with SW_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- fifo_empty_i  in  P_NUM_PORTS  empty flags of the ingress FIFOs.
- fifo_data_i  in  P_NUM_PORTS*P_DATA_WIDTH  FWFT head data; port k occupies bits [k*W +: W].
- fifo_last_i  in  P_NUM_PORTS  end-of-frame flag of each FIFO head.
- fifo_rd_o  out  P_NUM_PORTS  pop strobes, at most one bit high.
- m_data_o  out  P_DATA_WIDTH  egress data.
- m_last_o  out  1  egress end-of-frame.
- m_valid_o  out  1  egress beat valid.
- m_ready_i  in  1  egress sink ready.
- grant_o  out  P_NUM_PORTS  one-hot current grant; zero when idle.
- busy_o  out  1  high while in XFER.
- frame_cnt_o  out  16  frames completed; wraps 0xFFFF->0.
- abort_o  out  1  one-cycle pulse on timeout abort (tied 0 without the macro).

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; grant_o=0; busy_o=0; fifo_rd_o=0; m_valid_o=0; m_last_o=0; m_data_o=0; frame_cnt_o=0; abort_o=0.
  - Round-robin pointer last_grant=P_NUM_PORTS-1, so port 0 has first priority.
  - Reset asserted mid-frame drops the grant immediately. FIFO contents are not touched; the partially sent frame stays truncated.
- IDLE:
  - If any fifo_empty_i bit is 0, pick the first non-empty port scanning last_grant+1, last_grant+2, ... modulo P_NUM_PORTS.
  - On the next edge: register grant, set last_grant to that port, go to XFER.
  - There is no pop in IDLE, so each frame has a one-cycle arbitration bubble.
- XFER, combinational:
  - m_valid_o = ~fifo_empty_i[g].
  - m_data_o = fifo_data_i[g]; m_last_o = fifo_last_i[g].
  - fifo_rd_o[g] = m_valid_o & m_ready_i; all other bits 0.
  - Zero latency, FIFO head to egress.
- XFER, transfer accepted (valid & ready):
  - With m_last_o=1: frame_cnt_o++, grant_o->0, go to IDLE.
  - Otherwise stay in XFER.
- m_valid_o never depends on m_ready_i. Once m_valid_o is asserted it stays asserted with stable data until accepted, because the FIFO head is only popped by this block.
- The granted FIFO going empty mid-frame: m_valid_o=0, grant is held, no other port is served.
- Non-granted ports are ignored until IDLE regardless of their fill state.
- Single port continuously non-empty: it is re-granted after each frame with one bubble cycle between frames.
- grant_o, busy_o, frame_cnt_o and abort_o are registered. m_* and fifo_rd_o are combinational from the registered grant.

Optional Feature:
- Macro: SW_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit stall counter counts consecutive XFER cycles with fifo_empty_i[g]=1. It clears on any accepted beat and on entry to XFER.
  - On reaching P_TIMEOUT: abort_o pulses for one cycle, grant is released, state goes to IDLE, frame_cnt_o is not incremented. Round robin advances past the aborted port.
- Undefined: no counter is instantiated; abort_o is tied 0; a starved grant is held indefinitely.

Decomposition:
- Package sw_arb_pkg:
  - state enum typedef arb_state_t {IDLE, XFER}.
  - Function clog2-based index width for P_NUM_PORTS.
  - FRAME_CNT_WIDTH=16.
- Sub-module rr_pick (purely combinational):
  - Inputs: request vector, last_grant index.
  - Outputs: one-hot grant, index, any_req.
  - Implemented with a double-width rotate and priority encode. Reusable by the ingress scheduler.

Test Plan:
- Reset release with all FIFOs empty -> grant_o=0, m_valid_o=0, fifo_rd_o=0 for 20 cycles.
- Ports 0 and 2 each hold a 3-beat frame (0xA1,0xA2,0xA3 / 0xC1,0xC2,0xC3 with last on the 3rd beat), m_ready_i=1:
  - Egress sees A1 A2 A3 (bubble) C1 C2 C3.
  - frame_cnt_o=2; fifo_rd_o one-hot only during accepted beats.
- All 4 ports hold 2 frames each -> grant order 0,1,2,3,0,1,2,3; no port is granted twice consecutively while others request.
- Backpressure: m_ready_i toggles 1,0,0,1 during a 4-beat frame -> m_data_o and m_valid_o are stable through the stalls; exactly 4 pops; the last beat pops on the cycle it is accepted.
- Starvation (SW_ARB_TIMEOUT_EN, P_TIMEOUT=8):
  - Setup: port 1 sends 2 beats with no last then runs empty; port 3 holds a frame.
  - Response: abort_o pulses after 8 stalled cycles, then port 3's frame is sent, frame_cnt_o=1.
  - Without the macro, the grant stays on port 1.
- rst_ni pulsed low mid-frame on beat 2 of 5 -> all outputs go to reset values asynchronously; after release, port 0 is arbitrated first.
